// File: rtl/bullet_pkg.sv
// ---------------------------------------------------------------------------
// bullet_pkg : shared state encoding and geometry for the bullet scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bullet_pkg;

  localparam int X_W        = 9;
  localparam int Y_W        = 8;
  localparam int BULLET_LEN = 4;

  localparam logic [2:0] COLOUR_ERASE      = 3'b000;
  localparam logic [2:0] BULLET_COLOUR_DEF = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERASE = 3'd1,
    S_MOVE  = 3'd2,
    S_DRAW  = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bullet_slot_alloc.sv
// ---------------------------------------------------------------------------
// bullet_slot_alloc : finds the lowest-numbered free bullet slot
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bullet_slot_alloc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     active_mask,
  output logic [IDX_W-1:0] free_idx,
  output logic             free_valid
);

  // Scan from the top down so the last hit is the lowest free slot.
  always_comb begin
    free_idx   = '0;
    free_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!active_mask[i]) begin
        free_idx   = IDX_W'(i);
        free_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bullet_scheduler.sv
// ---------------------------------------------------------------------------
// bullet_scheduler : per-frame erase/move/redraw walk over all player bullets
// Optional spawn cooldown enabled by defining BULLET_COOLDOWN_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bullet_scheduler import bullet_pkg::*; #(
  parameter int         NUM_BULLETS   = 4,
  parameter int         SPEED         = 2,
  parameter logic [2:0] BULLET_COLOUR = BULLET_COLOUR_DEF,
  parameter int         FIRE_COOLDOWN = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   fire,
  input  logic [X_W-1:0]         ship_x,
  input  logic [Y_W-1:0]         ship_y,
  input  logic [NUM_BULLETS-1:0] kill,
  output logic                   draw_en,
  output logic [X_W-1:0]         draw_x,
  output logic [Y_W-1:0]         draw_y,
  output logic [2:0]             draw_colour,
  input  logic                   draw_done,
  output logic                   busy,
  output logic [NUM_BULLETS-1:0] active_mask,
  output logic                   overrun
);

  localparam int              IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam logic [Y_W-1:0]  MIN_Y = Y_W'(SPEED + BULLET_LEN - 1);
  localparam logic [Y_W-1:0]  STEP  = Y_W'(SPEED);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BULLETS - 1);

  // The cooldown counter is 8 bits wide; larger settings could never be reached.
  if (FIRE_COOLDOWN < 0 || FIRE_COOLDOWN > 255) begin : g_cooldown_range
  end

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [X_W-1:0]         xs [NUM_BULLETS];
  logic [Y_W-1:0]         ys [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] active;
  logic [NUM_BULLETS-1:0] drawn;
  logic [NUM_BULLETS-1:0] dying;
  logic                   fresh;
  logic                   fire_pending;

  logic [IDX_W-1:0]       free_idx;
  logic                   free_valid;
  logic                   spawn_ok;
  logic                   do_spawn;
  logic [IDX_W-1:0]       next_idx;
  logic [Y_W-1:0]         moved_y;

  assign active_mask = active;
  assign next_idx    = idx + 1'b1;
  assign moved_y     = ys[idx] - STEP;
  assign do_spawn    = (state == S_IDLE) && !frame_tick && fire_pending && spawn_ok;

  bullet_slot_alloc #(
    .N     (NUM_BULLETS),
    .IDX_W (IDX_W)
  ) u_alloc (
    .active_mask (active),
    .free_idx    (free_idx),
    .free_valid  (free_valid)
  );

`ifdef BULLET_COOLDOWN_EN
  localparam logic [7:0] CD_MAX = 8'(FIRE_COOLDOWN);
  logic [7:0] cd_cnt;

  assign spawn_ok = free_valid && (cd_cnt == CD_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cd_cnt <= CD_MAX;
    end else if (do_spawn) begin
      cd_cnt <= 8'd0;
    end else if (frame_tick && (cd_cnt != CD_MAX)) begin
      cd_cnt <= cd_cnt + 8'd1;
    end
  end
`else
  assign spawn_ok = free_valid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      active       <= '0;
      drawn        <= '0;
      dying        <= '0;
      fresh        <= 1'b0;
      fire_pending <= 1'b0;
      draw_en      <= 1'b0;
      draw_x       <= '0;
      draw_y       <= '0;
      draw_colour  <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
    end else begin
      overrun <= frame_tick && busy;
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            busy        <= 1'b1;
            idx         <= '0;
            draw_x      <= xs[0];
            draw_y      <= ys[0];
            draw_colour <= COLOUR_ERASE;
            state       <= S_ERASE;
          end else if (fire_pending) begin
            fire_pending <= 1'b0;
            if (do_spawn) begin
              xs[free_idx]     <= ship_x;
              ys[free_idx]     <= ship_y - 8'd1;
              active[free_idx] <= 1'b1;
              drawn[free_idx]  <= 1'b0;
              dying[free_idx]  <= 1'b0;
            end
          end
        end
        S_ERASE: begin
          if (draw_en) begin
            if (draw_done) begin
              draw_en    <= 1'b0;
              drawn[idx] <= 1'b0;
              state      <= S_MOVE;
            end
          end else begin
            // Remember whether the bullet was on screen before this frame.
            fresh <= !drawn[idx];
            if (active[idx] && drawn[idx]) draw_en <= 1'b1;
            else                           state   <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (!active[idx]) begin
            state <= S_NEXT;
          end else if (dying[idx]) begin
            active[idx] <= 1'b0;
            dying[idx]  <= 1'b0;
            state       <= S_NEXT;
          end else if (!fresh && (ys[idx] < MIN_Y)) begin
            active[idx] <= 1'b0;
            state       <= S_NEXT;
          end else begin
            if (!fresh) ys[idx] <= moved_y;
            draw_x      <= xs[idx];
            draw_y      <= fresh ? ys[idx] : moved_y;
            draw_colour <= BULLET_COLOUR;
            state       <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (draw_en) begin
            if (draw_done) begin
              draw_en    <= 1'b0;
              drawn[idx] <= 1'b1;
              state      <= S_NEXT;
            end
          end else begin
            draw_en <= 1'b1;
          end
        end
        S_NEXT: begin
          if (idx == LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            idx         <= next_idx;
            draw_x      <= xs[next_idx];
            draw_y      <= ys[next_idx];
            draw_colour <= COLOUR_ERASE;
            state       <= S_ERASE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (fire) fire_pending <= 1'b1;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (kill[i] && active[i]) dying[i] <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/bullet_scheduler.md
# bullet_scheduler

Owns every player bullet on screen and drives the bullet plotter. On each frame tick it walks all bullet slots, erasing each bullet at its old position, moving it up, and redrawing it, via the plotter's enable/done handshake. It sits between the game-control FSM (fire, frame tick, collision kills) and the bullet plotter, whose VGA pixel outputs it does not touch.

## Interface
- NUM_BULLETS, 4: slot count (1..8).
- SPEED, 2: pixels moved up per frame (1..15).
- BULLET_COLOUR, 3'b111: draw colour; erase colour is 3'b000.
- FIRE_COOLDOWN, 8: frames between spawns (used only with BULLET_COOLDOWN_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse, start of frame update.
- fire  in  1  one-cycle spawn request.
- ship_x  in  9  spawn x.
- ship_y  in  8  ship top row; bullet base y = ship_y − 1.
- kill  in  NUM_BULLETS  per-slot collision removal, one-cycle pulses.
- draw_en  out  1  plotter enable.
- draw_x  out  9  plotter x_pos_init.
- draw_y  out  8  plotter y_pos_init (bullet base row; plotter draws base..base−3).
- draw_colour  out  3  colour for current transaction.
- draw_done  in  1  plotter done.
- busy  out  1  frame walk in progress.
- active_mask  out  NUM_BULLETS  slot occupied.
- overrun  out  1  one-cycle pulse: frame_tick arrived while busy.

## Operation
- Per slot: x[8:0], y[7:0], active, drawn (pixels on screen), dying (kill pending).
- States: IDLE, ERASE, MOVE, DRAW, NEXT.
- IDLE: frame_tick → busy=1, idx=0, go to ERASE. Otherwise service fire_pending: allocate lowest free slot (x=ship_x, y=ship_y−1, active=1, drawn=0); none free → request dropped. fire_pending clears either way.
- ERASE: slot inactive or drawn=0 → skip to MOVE with no transaction. Else transaction with colour 3'b000 at (x,y); on done drawn=0.
- MOVE (1 cycle): inactive → NEXT. dying → active=0, dying=0, NEXT. Fresh slot (drawn=0 before this frame) → no move. Else y < SPEED+3 → active=0 (top pixel would underflow), NEXT; else y −= SPEED. Arithmetic 8-bit unsigned, never wraps.
- DRAW: transaction with BULLET_COLOUR; on done drawn=1. → NEXT.
- NEXT: idx == NUM_BULLETS−1 → IDLE, busy=0; else idx+1, ERASE.
- fire arriving while busy sets fire_pending; serviced in first IDLE cycle. fire and frame_tick in the same IDLE cycle: frame walk first, spawn after.
- kill on an active slot sets dying (erased at next frame, then freed); kill on inactive slot ignored. kill on the slot currently in DRAW takes effect next frame.
- frame_tick while busy: ignored, overrun pulses.

## Timing
- Transaction: draw_en registered; rises the cycle after entering ERASE/DRAW. draw_x/y/colour stable from one cycle before draw_en rises until it falls.
- draw_done sampled only while draw_en=1 (plotter reports done=1 when disabled). On the edge where draw_en=1 and draw_done=1, draw_en clears; next state follows. draw_en is never high in the cycle after done is sampled, so the plotter returns to its wait state without re-triggering.
- Plotter transaction is 6 cycles with enable high; walk of N live bullets ≈ 2·N·8 cycles.
- Reset (async, any state, mid-transaction included): state IDLE, all slots cleared, fire_pending 0, draw_en 0, draw_x 0, draw_y 0, draw_colour 0, busy 0, active_mask 0, overrun 0. A half-drawn bullet is left on screen; the top level clears the screen on reset.

## Configuration
- BULLET_COOLDOWN_EN defined: 8-bit frame counter saturating at FIRE_COOLDOWN, zeroed on each spawn; fire_pending is serviced only when counter == FIRE_COOLDOWN, otherwise dropped. Counter resets to FIRE_COOLDOWN.
- Undefined: no counter, every fire spawns if a slot is free.

## Structure
- bullet_pkg: state encoding, X_W=9, Y_W=8, BULLET_LEN=4, COLOUR_ERASE, default BULLET_COLOUR.
- Sub-module bullet_slot_alloc: lowest-free-slot finder over active_mask, outputs index and valid.

## Test plan
- Reset, fire with ship (100,200), frame_tick → no erase; one DRAW at (100,199) colour 7; active_mask=0001.
- Second frame_tick → erase at (100,199) colour 0, then draw at (100,197).
- Bullet at y=4, SPEED=2, frame_tick → erase only, active_mask bit clears, no draw.
- Five fires with NUM_BULLETS=4 → slots 0..3 fill, fifth dropped, mask=1111.
- kill[1] then frame_tick → slot 1 erased, not redrawn, freed; draw_en never re-asserts while plotter holds done.
- frame_tick during walk → overrun pulses one cycle; reset mid-DRAW → draw_en=0 and mask=0 immediately.
